bank_mapper: RTL and testbench
==============================

// Module: bank_mapper
// PURPOSE
//  Parametrised successor to the 6502-in-6509 bank adapter. Maps a 16-bit 6502 bus onto a BANK_BITS-wide bank
//  address using two memory-mapped bank registers (execution, indirect). Tracks LDA/STA (zp),Y sequences to steer
//  the data cycle to the indirect bank. Width beyond 4 bits ("full mode") is gated by a key-sequence unlock FSM.
//  Sits between the CPU socket and the system bus; the address_bank output drives the upper address lines.
// PARAMETERS
//  BANK_BITS   8        bank address width, 4..8
//  RESET_BANK  8'h0F    reset value of both bank registers, masked to BANK_BITS
//  EXEC_ADDR   16'h0000 execution bank register address
//  IND_ADDR    16'h0001 indirect bank register address
//  KEY0/1/2    8'h55/8'hAA/8'h00  unlock key bytes written to IND_ADDR
// PORTS
//  phi2_6509     in   1          system clock; all state updates on rising edge
//  reset         in   1          synchronous, active-high reset
//  r_w           in   1          1 = read, 0 = write
//  _rdy          in   1          0 = CPU stalled; freezes the sequence tracker
//  sync          in   1          opcode fetch cycle
//  address_6502  in   16         CPU address
//  data_in       in   8          CPU data, valid in the cycle it is sampled
//  data_out      out  8          register readback data
//  data_oe       out  1          1 = drive data_out onto the CPU bus
//  address_bank  out  BANK_BITS  current bank address
//  flag_full     out  1          1 = full-width bank mode active
//  ind_active    out  1          1 = address_bank currently sourced from the indirect register
// BEHAVIOUR
//  Reset: exec_reg = ind_reg = RESET_BANK; tracker IDLE; unlock state K0; flag_full = 0; data_oe = 0; data_out = 0.
//  Register write: edge where !r_w & address == EXEC_ADDR/IND_ADDR loads data_in[BANK_BITS-1:0]; ignores _rdy;
//   visible on address_bank from the next cycle.
//  Masking: flag_full = 0 -> bits [BANK_BITS-1:4] of every output/readback forced to 0 (stored bits preserved).
//  Readback (combinational): r_w & address match -> data_oe = 1, data_out = masked register, zero-extended to 8
//   bits; otherwise data_oe = 0, data_out = 0.
//  Tracker states: IDLE, OPND, PLO, PHI, FIX, DATA. Advances only when _rdy = 1.
//   IDLE -> OPND when sync & data_in is 8'h91 or 8'hB1 (mask 8'b10x10001).
//   OPND -> PLO -> PHI -> FIX -> DATA -> IDLE, one step per ready edge.
//   sync = 1 in FIX or DATA: abort to IDLE, or to OPND if that fetch is itself a match.
//  address_bank = ind_reg (masked) when state is FIX or DATA and !sync; else exec_reg (masked).
//   ind_active mirrors that select.
//  _rdy low: state and select held, including mid-sequence; writes still land.
//  Simultaneous write to a bank register during FIX/DATA: select uses the old value this cycle, the new one next.
//  Reset mid-sequence: returns to IDLE; the next cycle uses RESET_BANK.
// CONFIGURATION
//  LOCK_SEQ_EN defined: unlock FSM K0 -K0key-> K1 -K1key-> K2 -K2key-> K3.
//   On each write to IND_ADDR: K3 -> K0 with flag_full <= data_in[0]. A mismatch goes to K0,
//   or to K1 if the byte equals KEY0. Writes to other addresses leave the state unchanged.
//  LOCK_SEQ_EN undefined: no FSM; flag_full tied 1 when BANK_BITS > 4, else 0.
// STRUCTURE
//  bank_pkg: tracker state enum; unlock state enum; OPC_IND_MASK/OPC_IND_VAL constants; width-mask function.
//  Sub-module bank_unlock_fsm (key sequence -> flag_full), instantiated only under LOCK_SEQ_EN.
// TESTING
//  1 Reset, read 0000/0001 -> data_oe = 1, data_out = 8'h0F; address_bank = 8'h0F; flag_full = 0.
//  2 Write 0000 <= 8'h23 (locked) -> address_bank = 8'h03; readback 8'h03.
//  3 LOCK_SEQ_EN: write 0001 <= 55, AA, 00, 01 -> flag_full = 1; address_bank = 8'h23.
//    Sequence 55, 12, ... -> stays 0.
//  4 exec = 3, ind = 7; fetch 8'hB1 with sync, then 5 ready cycles -> address_bank = 7 only in FIX/DATA;
//    3 at the next sync.
//  5 Same as 4 with _rdy = 0 for 3 cycles in PHI -> FIX entry delayed 3 cycles; bank sequence unchanged.
//  6 Assert reset during FIX -> next cycle IDLE, address_bank = 8'h0F, flag_full = 0.

Source files
------------

// File: rtl/bank_pkg.sv
// Shared types and constants for the bank mapper.
// Tracker and unlock state encodings, the (zp),Y opcode match pattern
// and the helper that hides the upper bank bits while locked.
package bank_pkg;

    // Sequence tracker for LDA/STA (zp),Y: opcode fetch, operand, pointer lo/hi,
    // page-fix dummy cycle, data cycle.
    typedef enum logic [2:0] {
        TRK_IDLE = 3'd0,
        TRK_OPND = 3'd1,
        TRK_PLO  = 3'd2,
        TRK_PHI  = 3'd3,
        TRK_FIX  = 3'd4,
        TRK_DATA = 3'd5
    } trk_state_t;

    // Key-sequence unlock states; K3 means the three keys have been seen.
    typedef enum logic [1:0] {
        UL_K0 = 2'd0,
        UL_K1 = 2'd1,
        UL_K2 = 2'd2,
        UL_K3 = 2'd3
    } unlock_state_t;

    // 8'h91 (STA (zp),Y) and 8'hB1 (LDA (zp),Y) differ only in bit 5.
    localparam logic [7:0] OPC_IND_MASK = 8'b1101_1111;
    localparam logic [7:0] OPC_IND_VAL  = 8'b1001_0001;

    // Clear bits [7:4] unless full-width mode is active.
    function automatic logic [7:0] width_mask(input logic [7:0] value, input logic full);
        return full ? value : {4'b0000, value[3:0]};
    endfunction

endpackage

// File: rtl/bank_unlock_fsm.sv
// Key-sequence unlock for full-width bank mode.
// Watches writes to the indirect register; after KEY0, KEY1, KEY2 the next
// write's bit 0 becomes the full-mode flag. Built only with LOCK_SEQ_EN.
module bank_unlock_fsm
    import bank_pkg::*;
#(
    parameter logic [7:0] KEY0 = 8'h55,
    parameter logic [7:0] KEY1 = 8'hAA,
    parameter logic [7:0] KEY2 = 8'h00
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       i_wr_ind,
    input  logic [7:0] i_data,
    output logic       o_flag_full
);

    unlock_state_t r_state;
    unlock_state_t w_state_next;
    logic          r_flag;
    logic          w_flag_next;
    logic          w_is_key0;

    assign w_is_key0 = (i_data == KEY0);

    // State and flag registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= UL_K0;
            r_flag  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_flag  <= w_flag_next;
        end
    end

    // Key matching: a wrong byte restarts, but a stray KEY0 counts as a fresh start.
    always_comb begin
        w_state_next = r_state;
        w_flag_next  = r_flag;
        if (i_wr_ind) begin
            unique case (r_state)
                UL_K0: w_state_next = w_is_key0 ? UL_K1 : UL_K0;
                UL_K1: w_state_next = (i_data == KEY1) ? UL_K2 : (w_is_key0 ? UL_K1 : UL_K0);
                UL_K2: w_state_next = (i_data == KEY2) ? UL_K3 : (w_is_key0 ? UL_K1 : UL_K0);
                UL_K3: begin
                    w_state_next = UL_K0;
                    w_flag_next  = i_data[0];
                end
                default: w_state_next = UL_K0;
            endcase
        end
    end

    assign o_flag_full = r_flag;

endmodule

// File: rtl/bank_mapper.sv
// 6502-on-banked-bus adapter: execution and indirect bank registers,
// (zp),Y sequence tracking to steer the data cycle to the indirect bank,
// and masking of the upper bank bits while full mode is off.
// Build option: LOCK_SEQ_EN adds the key-sequence unlock for full mode;
// without it full mode is permanently on whenever BANK_BITS > 4.
module bank_mapper
    import bank_pkg::*;
#(
    parameter int          BANK_BITS  = 8,
    parameter logic [7:0]  RESET_BANK = 8'h0F,
    parameter logic [15:0] EXEC_ADDR  = 16'h0000,
    parameter logic [15:0] IND_ADDR   = 16'h0001,
    parameter logic [7:0]  KEY0       = 8'h55,
    parameter logic [7:0]  KEY1       = 8'hAA,
    parameter logic [7:0]  KEY2       = 8'h00
) (
    input  logic                 phi2_6509,
    input  logic                 reset,
    input  logic                 r_w,
    input  logic                 _rdy,
    input  logic                 sync,
    input  logic [15:0]          address_6502,
    input  logic [7:0]           data_in,
    output logic [7:0]           data_out,
    output logic                 data_oe,
    output logic [BANK_BITS-1:0] address_bank,
    output logic                 flag_full,
    output logic                 ind_active
);

    localparam logic [BANK_BITS-1:0] RESET_VAL = RESET_BANK[BANK_BITS-1:0];

    logic [BANK_BITS-1:0] r_exec;
    logic [BANK_BITS-1:0] r_ind;
    trk_state_t           r_state;
    trk_state_t           w_state_next;

    logic                 w_hit_exec;
    logic                 w_hit_ind;
    logic                 w_wr_exec;
    logic                 w_wr_ind;
    logic                 w_opc_match;
    logic                 w_sel_ind;
    logic                 w_flag_full;
    logic [7:0]           w_exec_m8;
    logic [7:0]           w_ind_m8;
    logic [BANK_BITS-1:0] w_exec_masked;
    logic [BANK_BITS-1:0] w_ind_masked;

    assign w_hit_exec  = (address_6502 == EXEC_ADDR);
    assign w_hit_ind   = (address_6502 == IND_ADDR);
    assign w_wr_exec   = !r_w && w_hit_exec;
    assign w_wr_ind    = !r_w && w_hit_ind;
    assign w_opc_match = sync && ((data_in & OPC_IND_MASK) == OPC_IND_VAL);

`ifdef LOCK_SEQ_EN
    bank_unlock_fsm #(
        .KEY0 (KEY0),
        .KEY1 (KEY1),
        .KEY2 (KEY2)
    ) u_unlock (
        .clk         (phi2_6509),
        .srst        (reset),
        .i_wr_ind    (w_wr_ind),
        .i_data      (data_in),
        .o_flag_full (w_flag_full)
    );
`else
    // Nothing to unlock: wide banks are simply always available.
    assign w_flag_full = (BANK_BITS > 4);

    // Keys only matter when the lock is built in; fold them into a sink signal.
    logic w_unused_keys;
    assign w_unused_keys = ^{KEY0, KEY1, KEY2};
`endif

    // Bank registers load on any write edge, regardless of CPU stall.
    always_ff @(posedge phi2_6509) begin
        if (reset) begin
            r_exec <= RESET_VAL;
            r_ind  <= RESET_VAL;
        end else begin
            if (w_wr_exec) r_exec <= data_in[BANK_BITS-1:0];
            if (w_wr_ind)  r_ind  <= data_in[BANK_BITS-1:0];
        end
    end

    // Tracker state register.
    always_ff @(posedge phi2_6509) begin
        if (reset) r_state <= TRK_IDLE;
        else       r_state <= w_state_next;
    end

    // Tracker next state: one step per ready cycle; a new fetch in FIX/DATA
    // means the sequence ended early (no page cross), so restart from it.
    always_comb begin
        w_state_next = r_state;
        if (_rdy) begin
            unique case (r_state)
                TRK_IDLE: w_state_next = w_opc_match ? TRK_OPND : TRK_IDLE;
                TRK_OPND: w_state_next = TRK_PLO;
                TRK_PLO:  w_state_next = TRK_PHI;
                TRK_PHI:  w_state_next = TRK_FIX;
                TRK_FIX:  w_state_next = sync ? (w_opc_match ? TRK_OPND : TRK_IDLE) : TRK_DATA;
                TRK_DATA: w_state_next = sync ? (w_opc_match ? TRK_OPND : TRK_IDLE) : TRK_IDLE;
                default:  w_state_next = TRK_IDLE;
            endcase
        end
    end

    // Upper bits hidden while locked; the stored value keeps them.
    assign w_exec_m8     = width_mask(8'(r_exec), w_flag_full);
    assign w_ind_m8      = width_mask(8'(r_ind), w_flag_full);
    assign w_exec_masked = w_exec_m8[BANK_BITS-1:0];
    assign w_ind_masked  = w_ind_m8[BANK_BITS-1:0];

    // Indirect bank only for the pointer-addressed cycles, never for a fetch.
    assign w_sel_ind    = ((r_state == TRK_FIX) || (r_state == TRK_DATA)) && !sync;
    assign address_bank = w_sel_ind ? w_ind_masked : w_exec_masked;
    assign ind_active   = w_sel_ind;
    assign flag_full    = w_flag_full;

    // Register readback onto the CPU data bus.
    always_comb begin
        data_oe  = 1'b0;
        data_out = 8'h00;
        if (r_w && w_hit_exec) begin
            data_oe  = 1'b1;
            data_out = 8'(w_exec_masked);
        end else if (r_w && w_hit_ind) begin
            data_oe  = 1'b1;
            data_out = 8'(w_ind_masked);
        end
    end

endmodule

// File: tb/tb_bank_mapper.sv
// Directed bench for bank_mapper: reset, register write/readback and
// masking, unlock sequence (or tied flag), (zp),Y steering, stalls,
// aborts and reset mid-sequence.
module tb_bank_mapper;

`ifdef LOCK_SEQ_EN
    localparam logic FULL_RST = 1'b0;
`else
    localparam logic FULL_RST = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rw;
    logic        rdy;
    logic        sync_s;
    logic [15:0] addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        doe;
    logic [7:0]  abank;
    logic        ffull;
    logic        iact;

    int n_tests = 0;
    int n_fail  = 0;

    bank_mapper dut (
        .phi2_6509    (clk),
        .reset        (rst),
        .r_w          (rw),
        ._rdy         (rdy),
        .sync         (sync_s),
        .address_6502 (addr),
        .data_in      (din),
        .data_out     (dout),
        .data_oe      (doe),
        .address_bank (abank),
        .flag_full    (ffull),
        .ind_active   (iact)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        rw = 1'b0; addr = a; din = d;
        tick();
        rw = 1'b1; addr = 16'h8000; din = 8'h00;
        $display("[TB] write %h <= %h", a, d);
    endtask

    task automatic fetch(input logic [7:0] opc);
        sync_s = 1'b1; din = opc; addr = 16'h2000;
        tick();
        sync_s = 1'b0; din = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1; rw = 1'b1; rdy = 1'b1; sync_s = 1'b0; addr = 16'h8000; din = 8'h00;
        tick(); tick();
        rst = 1'b0;
        #2;
        n_tests++; if (abank !== 8'h0F) begin n_fail++; $display("FAIL rst_bank: got %h want 0f", abank); end
        n_tests++; if (ffull !== FULL_RST) begin n_fail++; $display("FAIL rst_flag: got %b want %b", ffull, FULL_RST); end
        n_tests++; if (doe !== 1'b0 || iact !== 1'b0) begin n_fail++; $display("FAIL rst_idle: oe %b ind %b want 0 0", doe, iact); end
        addr = 16'h0000; #2;
        n_tests++; if (doe !== 1'b1 || dout !== 8'h0F) begin n_fail++; $display("FAIL rd_exec_rst: oe %b data %h want 1 0f", doe, dout); end
        addr = 16'h0001; #2;
        n_tests++; if (doe !== 1'b1 || dout !== 8'h0F) begin n_fail++; $display("FAIL rd_ind_rst: oe %b data %h want 1 0f", doe, dout); end
        $display("[TB] reset: bank %h flag %b", abank, ffull);
        addr = 16'h8000;
    endtask

    task automatic test_write_mask();
        logic [7:0] exp;
        exp = FULL_RST ? 8'h23 : 8'h03;
        rw = 1'b0; addr = 16'h0000; din = 8'h23; #2;
        n_tests++; if (doe !== 1'b0) begin n_fail++; $display("FAIL wr_no_oe: got %b want 0", doe); end
        n_tests++; if (abank !== 8'h0F) begin n_fail++; $display("FAIL wr_same_cycle: got %h want 0f", abank); end
        tick();
        rw = 1'b1; addr = 16'h8000; din = 8'h00; #2;
        n_tests++; if (abank !== exp) begin n_fail++; $display("FAIL wr_bank: got %h want %h", abank, exp); end
        addr = 16'h0000; #2;
        n_tests++; if (dout !== exp) begin n_fail++; $display("FAIL wr_readback: got %h want %h", dout, exp); end
        addr = 16'h0001; #2;
        n_tests++; if (dout !== 8'h0F) begin n_fail++; $display("FAIL wr_ind_untouched: got %h want 0f", dout); end
        $display("[TB] write 0000<=23: bank %h", abank);
        addr = 16'h8000;
    endtask

    task automatic test_unlock();
`ifdef LOCK_SEQ_EN
        logic [7:0] bad [5];
        logic [7:0] good [5];
        bad  = '{8'h55, 8'h12, 8'hAA, 8'h00, 8'h01};
        good = '{8'h55, 8'h55, 8'hAA, 8'h00, 8'h01};
        foreach (bad[i]) wr(16'h0001, bad[i]);
        #2;
        n_tests++; if (ffull !== 1'b0) begin n_fail++; $display("FAIL unlock_bad: flag %b want 0", ffull); end
        n_tests++; if (abank !== 8'h03) begin n_fail++; $display("FAIL unlock_bad_bank: got %h want 03", abank); end
        for (int i = 0; i < 4; i++) wr(16'h0001, good[i]);
        #2;
        n_tests++; if (ffull !== 1'b0) begin n_fail++; $display("FAIL unlock_early: flag %b want 0", ffull); end
        wr(16'h0001, good[4]);
        #2;
        n_tests++; if (ffull !== 1'b1) begin n_fail++; $display("FAIL unlock_flag: got %b want 1", ffull); end
        n_tests++; if (abank !== 8'h23) begin n_fail++; $display("FAIL unlock_bank: got %h want 23", abank); end
        addr = 16'h0001; #2;
        n_tests++; if (dout !== 8'h01) begin n_fail++; $display("FAIL unlock_ind_rd: got %h want 01", dout); end
`else
        wr(16'h0001, 8'h55); wr(16'h0001, 8'hAA); wr(16'h0001, 8'h00); wr(16'h0001, 8'h00);
        #2;
        n_tests++; if (ffull !== 1'b1) begin n_fail++; $display("FAIL tied_flag: got %b want 1", ffull); end
        n_tests++; if (abank !== 8'h23) begin n_fail++; $display("FAIL tied_bank: got %h want 23", abank); end
`endif
        $display("[TB] unlock: flag %b bank %h", ffull, abank);
        addr = 16'h8000;
    endtask

    task automatic test_indirect();
        logic [7:0] exp_b [5];
        exp_b = '{8'h03, 8'h03, 8'h03, 8'h07, 8'h07};
        wr(16'h0000, 8'h03);
        wr(16'h0001, 8'h07);
        sync_s = 1'b1; din = 8'hB1; addr = 16'h2000; #2;
        n_tests++; if (abank !== 8'h03 || iact !== 1'b0) begin n_fail++; $display("FAIL ind_fetch: bank %h ind %b want 03 0", abank, iact); end
        tick();
        sync_s = 1'b0; din = 8'h00;
        for (int i = 0; i < 5; i++) begin
            #2;
            n_tests++;
            if (abank !== exp_b[i] || iact !== (exp_b[i] == 8'h07)) begin
                n_fail++; $display("FAIL ind_seq[%0d]: bank %h ind %b want %h", i, abank, iact, exp_b[i]);
            end
            tick();
        end
        sync_s = 1'b1; din = 8'hEA; #2;
        n_tests++; if (abank !== 8'h03) begin n_fail++; $display("FAIL ind_next_sync: got %h want 03", abank); end
        tick();
        $display("[TB] (zp),Y B1: indirect bank seen in FIX/DATA");
        // Non-matching opcode must not start a sequence.
        fetch(8'hB5);
        for (int i = 0; i < 5; i++) begin
            #2;
            n_tests++; if (abank !== 8'h03) begin n_fail++; $display("FAIL nomatch[%0d]: got %h want 03", i, abank); end
            tick();
        end
        // Fetch during FIX aborts the sequence.
        fetch(8'h91); tick(); tick(); tick();
        #2;
        n_tests++; if (abank !== 8'h07) begin n_fail++; $display("FAIL abort_fix: got %h want 07", abank); end
        sync_s = 1'b1; din = 8'hEA; #2;
        n_tests++; if (abank !== 8'h03 || iact !== 1'b0) begin n_fail++; $display("FAIL abort_sync: bank %h ind %b want 03 0", abank, iact); end
        tick();
        sync_s = 1'b0; din = 8'h00; #2;
        n_tests++; if (abank !== 8'h03) begin n_fail++; $display("FAIL abort_idle: got %h want 03", abank); end
        tick();
        // Matching fetch during DATA restarts the sequence.
        fetch(8'hB1); tick(); tick(); tick(); tick();
        sync_s = 1'b1; din = 8'h91; #2;
        n_tests++; if (abank !== 8'h03) begin n_fail++; $display("FAIL restart_sync: got %h want 03", abank); end
        tick();
        sync_s = 1'b0; din = 8'h00;
        tick(); tick(); tick();
        #2;
        n_tests++; if (abank !== 8'h07) begin n_fail++; $display("FAIL restart_fix: got %h want 07", abank); end
        tick(); tick();
        #2;
        n_tests++; if (abank !== 8'h03) begin n_fail++; $display("FAIL restart_end: got %h want 03", abank); end
        $display("[TB] abort/restart: bank %h", abank);
    endtask

    task automatic test_stall();
        logic       rdy_v [9];
        logic [7:0] exp_b [9];
        rdy_v = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_b = '{8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h07, 8'h07, 8'h03};
        fetch(8'hB1);
        for (int i = 0; i < 9; i++) begin
            rdy = rdy_v[i]; #2;
            n_tests++; if (abank !== exp_b[i]) begin n_fail++; $display("FAIL stall_phi[%0d]: got %h want %h", i, abank, exp_b[i]); end
            tick();
        end
        rdy = 1'b1;
        $display("[TB] stall in PHI: FIX delayed 3 cycles");
        // Stall in FIX with a write to the indirect register.
        fetch(8'hB1); tick(); tick(); tick();
        rdy = 1'b0; rw = 1'b0; addr = 16'h0001; din = 8'h09; #2;
        n_tests++; if (abank !== 8'h07 || iact !== 1'b1) begin n_fail++; $display("FAIL wr_fix_old: bank %h ind %b want 07 1", abank, iact); end
        tick();
        rdy = 1'b1; rw = 1'b1; addr = 16'h2000; din = 8'h00; #2;
        n_tests++; if (abank !== 8'h09 || iact !== 1'b1) begin n_fail++; $display("FAIL wr_fix_new: bank %h ind %b want 09 1", abank, iact); end
        tick(); #2;
        n_tests++; if (abank !== 8'h09) begin n_fail++; $display("FAIL wr_fix_data: got %h want 09", abank); end
        tick(); #2;
        n_tests++; if (abank !== 8'h03) begin n_fail++; $display("FAIL wr_fix_idle: got %h want 03", abank); end
        $display("[TB] write during stalled FIX: new bank next cycle");
    endtask

    task automatic test_reset_mid();
        wr(16'h0001, 8'h07);
        fetch(8'hB1); tick(); tick(); tick();
        #2;
        n_tests++; if (abank !== 8'h07) begin n_fail++; $display("FAIL rmid_fix: got %h want 07", abank); end
        rst = 1'b1;
        tick();
        rst = 1'b0; #2;
        n_tests++; if (abank !== 8'h0F || iact !== 1'b0) begin n_fail++; $display("FAIL rmid_bank: bank %h ind %b want 0f 0", abank, iact); end
        n_tests++; if (ffull !== FULL_RST) begin n_fail++; $display("FAIL rmid_flag: got %b want %b", ffull, FULL_RST); end
        tick(); #2;
        n_tests++; if (abank !== 8'h0F || iact !== 1'b0) begin n_fail++; $display("FAIL rmid_idle: bank %h ind %b want 0f 0", abank, iact); end
        $display("[TB] reset in FIX: bank %h flag %b", abank, ffull);
    endtask

    initial begin
        test_reset();
        test_write_mask();
        test_unlock();
        test_indirect();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
